// File: rtl/key_schedule_pkg.sv
// Shared AES-128 key-expansion constants, FSM states and GF(2^8) helpers.
package key_schedule_pkg;

    localparam int NR = 10;
    localparam int NK = 11;
    localparam int RK_AW = 4;

    localparam logic [RK_AW-1:0] LAST_RND = RK_AW'(NR);
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_schedule_subword.sv
// Single AES-128 key-expansion round, two-stage pipeline (2-cycle latency).
module key_subword
    import key_schedule_pkg::*;
(
    input  logic         clk,
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gmul(gmul(x, x), x);
        x7   = gmul(gmul(x3, x3), x);
        x15  = gmul(gmul(x7, x7), x);
        x31  = gmul(gmul(x15, x15), x);
        x63  = gmul(gmul(x31, x31), x);
        x127 = gmul(gmul(x63, x63), x);
        return gmul(x127, x127);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [31:0]  w3;
    logic [31:0]  t;
    logic [127:0] key_q;
    logic [31:0]  t_q;
    logic [31:0]  n0, n1, n2, n3;

    // RotWord then SubWord, rcon folded into the lowest byte.
    always_comb begin
        w3 = key_in[127:96];
        t  = {sbox(w3[7:0]), sbox(w3[31:24]),
              sbox(w3[23:16]), sbox(w3[15:8]) ^ rcon};
    end

    always_comb begin
        n0 = key_q[31:0] ^ t_q;
        n1 = key_q[63:32] ^ n0;
        n2 = key_q[95:64] ^ n1;
        n3 = key_q[127:96] ^ n2;
    end

    always_ff @(posedge clk) begin
        key_q   <= key_in;
        t_q     <= t;
        key_out <= {n3, n2, n1, n0};
    end

endmodule

// File: rtl/key_schedule.sv
// Iterative AES-128 key-expansion controller with an 11-entry round-key
// store and a registered read port.
module key_schedule
    import key_schedule_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [127:0]     key_in,
    output logic             done,
    output logic [NK-1:0]    rk_valid,
    input  logic [RK_AW-1:0] rk_rd_addr,
    output logic [127:0]     rk_rd_data
);

    state_t             state;
    logic [RK_AW-1:0]   round;
    logic [1:0]         phase;
    logic [7:0]         rcon;
    logic [127:0]       cur_key;
    logic [127:0]       sub_out;
    logic [127:0]       rk [NK];
    logic               accept;
    logic               wr_en;

    assign accept = key_valid && key_ready;
    assign wr_en  = (state == RUN) && (phase == 2'd2);

    key_subword u_subword (
        .clk     (clk),
        .key_in  (cur_key),
        .rcon    (rcon),
        .key_out (sub_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_ready <= 1'b1;
            done      <= 1'b0;
            rk_valid  <= '0;
            round     <= '0;
            phase     <= 2'd0;
            rcon      <= RCON_INIT;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (key_valid) begin
                        state     <= RUN;
                        key_ready <= 1'b0;
                        done      <= 1'b0;
                        rk_valid  <= NK'(1);
                        round     <= RK_AW'(1);
                        phase     <= 2'd0;
                        rcon      <= RCON_INIT;
                    end
                end
                RUN: begin
                    unique case (phase)
                        2'd0: phase <= 2'd1;
                        2'd1: phase <= 2'd2;
                        2'd2: begin
                            rk_valid[round] <= 1'b1;
                            rcon            <= xtime(rcon);
                            phase           <= 2'd0;
                            if (round == LAST_RND) begin
                                state     <= DONE;
                                key_ready <= 1'b1;
                                done      <= 1'b1;
                            end else begin
                                round <= round + RK_AW'(1);
                            end
                        end
                        default: phase <= 2'd0;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store and working key are datapath only; reset does not clear them.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            rk[0]   <= key_in;
            cur_key <= key_in;
        end else if (rst_n && wr_en) begin
            rk[round] <= sub_out;
            cur_key   <= sub_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_rd_data <= '0;
        end else if (rk_rd_addr <= LAST_RND) begin
            rk_rd_data <= rk[rk_rd_addr];
        end else begin
            rk_rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_key_schedule.sv
// Scoreboard bench for key_schedule: reference AES-128 expansion feeds
// an expected-key queue that is drained through the read port.
module tb_key_schedule;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         done;
    logic [10:0]  rk_valid;
    logic [3:0]   rk_rd_addr;
    logic [127:0] rk_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] exp_q[$];
    logic [127:0] rd_keys [11];

    localparam logic [127:0] FIPS_KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] FIPS_RK1 = 128'h05766c2a3939a323b12c548817fefaa0;
    localparam logic [127:0] FIPS_RK10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic [7:0] sbox [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    key_schedule dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .done       (done),
        .rk_valid   (rk_valid),
        .rk_rd_addr (rk_rd_addr),
        .rk_rd_data (rk_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void push_keys(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sbox[t[7:0]], sbox[t[31:24]],
                      sbox[t[23:16]], sbox[t[15:8]] ^ rc};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            exp_q.push_back({w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]});
    endfunction

    task automatic run(input logic [127:0] k, input bit probe,
                       input bit busy, input logic [127:0] busy_key);
        int cnt;
        chk("ready_pre", key_ready, 1);
        key_valid = 1'b1;
        key_in    = k;
        push_keys(k);
        tick();
        key_valid = 1'b0;
        chk("ready_run", key_ready, 0);
        chk("done_run", done, 0);
        chk("valid_acc", rk_valid, 11'b1);
        cnt = 0;
        while (!done && cnt < 40) begin
            if (probe && cnt % 3 == 0 && cnt < 30) begin
                chk($sformatf("rcon%0d", cnt / 3), dut.rcon,
                    rcon_tab[cnt / 3]);
                chk($sformatf("vld%0d", cnt / 3), rk_valid,
                    (11'd1 << (cnt / 3 + 1)) - 11'd1);
            end
            if (cnt == 1) chk("rd_oob", rk_rd_data, 0);
            if (busy && cnt == 5) begin
                key_valid = 1'b1;
                key_in    = busy_key;
            end
            if (busy && cnt == 7) begin
                chk("ready_busy", key_ready, 0);
                key_valid = 1'b0;
            end
            tick();
            cnt++;
        end
        chk("latency", cnt, 30);
        chk("ready_done", key_ready, 1);
        chk("valid_all", rk_valid, 11'h7ff);
    endtask

    task automatic readback();
        logic [127:0] got;
        for (int r = 0; r < 11; r++) begin
            rk_rd_addr = 4'(r);
            tick();
            got = rk_rd_data;
            rd_keys[r] = got;
            if (exp_q.size() == 0) chk("sb_empty", 1, 0);
            else chk($sformatf("rk%0d", r), got, exp_q.pop_front());
        end
        rk_rd_addr = 4'd12;
        tick();
        chk("rd_addr12", rk_rd_data, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        key_valid  = 1'b0;
        key_in     = '0;
        rk_rd_addr = 4'd12;
        tick();
        tick();
        chk("rst_ready", key_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_rdata", rk_rd_data, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", key_ready, 1);

        run(FIPS_KEY, 1'b1, 1'b0, '0);
        readback();
        chk("fips_rk0", rd_keys[0], FIPS_KEY);
        chk("fips_rk1", rd_keys[1], FIPS_RK1);
        chk("fips_rk10", rd_keys[10], FIPS_RK10);

        run(128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 1'b1,
            128'hdeadbeef0123456789abcdeffedcba98);
        readback();

        key_valid = 1'b1;
        key_in    = 128'h00112233445566778899aabbccddeeff;
        tick();
        key_valid = 1'b0;
        repeat (13) tick();
        chk("mid_ready", key_ready, 0);
        rst_n = 1'b0;
        tick();
        chk("mrst_valid", rk_valid, 0);
        chk("mrst_done", done, 0);
        chk("mrst_ready", key_ready, 1);
        rst_n = 1'b1;
        tick();
        run(FIPS_KEY, 1'b0, 1'b0, '0);
        readback();
        chk("re_rk10", rd_keys[10], FIPS_RK10);

        run(128'hffffffff00000000ffffffff00000000, 1'b0, 1'b0, '0);
        readback();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
